// File: rtl/mult_nibble_seq.sv
// Sequential W x W unsigned multiplier that drives one external 4x4 tile,
// one nibble pair per cycle. Optional: MNS_ZERO_SKIP_EN (zero operand -> DONE).
module mult_nibble_seq #(
   parameter int unsigned W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   output logic [3:0]     mul_a,
   output logic [3:0]     mul_b,
   input  logic [7:0]     mul_p,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out_p,
   output logic           busy
);

   localparam int unsigned NN = W / 4;
   localparam int unsigned NP = NN * NN;
   localparam int unsigned IW = (NN > 1) ? $clog2(NN) : 1;
   localparam int unsigned PW = 2 * W;
   localparam logic [IW-1:0] ILast = IW'(NN - 1);

   if ((W % 4) != 0 || W < 4 || W > 16) begin : g_bad_w
      $error("mult_nibble_seq: W must be a multiple of 4 in 4..16");
   end

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e          state_q;
   logic [W-1:0]    a_q, b_q;
   logic [PW-1:0]   acc_q;
   logic [IW-1:0]   i_q, j_q;
   logic            in_ready_q, out_valid_q, busy_q;
   logic [PW-1:0]   out_p_q;

   logic [IW:0]     ij;
   logic [PW-1:0]   pp;
   logic [PW-1:0]   acc_nxt;
   logic            last_pass;
   logic            zero_op;

   // Tile operands come straight from the nibble indices; parked at zero
   // outside BUSY so the tile output is never consumed there.
   always_comb begin
      mul_a = 4'h0;
      mul_b = 4'h0;
      if (state_q == StBusy) begin
         mul_a = a_q[{i_q, 2'b00} +: 4];
         mul_b = b_q[{j_q, 2'b00} +: 4];
      end
   end

   always_comb begin
      ij        = {1'b0, i_q} + {1'b0, j_q};
      pp        = PW'(mul_p) << {ij, 2'b00};
      acc_nxt   = acc_q + pp;
      last_pass = (i_q == ILast) && (j_q == ILast);
   end

`ifdef MNS_ZERO_SKIP_EN
   assign zero_op = (in_a == '0) || (in_b == '0);
`else
   assign zero_op = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         i_q         <= '0;
         j_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         out_p_q     <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  a_q        <= in_a;
                  b_q        <= in_b;
                  acc_q      <= '0;
                  i_q        <= '0;
                  j_q        <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (zero_op) begin
                     state_q     <= StDone;
                     out_p_q     <= '0;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= StBusy;
                  end
               end
            end
            StBusy: begin
               acc_q <= acc_nxt;
               if (last_pass) begin
                  i_q         <= '0;
                  j_q         <= '0;
                  state_q     <= StDone;
                  out_p_q     <= acc_nxt;
                  out_valid_q <= 1'b1;
               end else if (j_q == ILast) begin
                  j_q <= '0;
                  i_q <= i_q + 1'b1;
               end else begin
                  j_q <= j_q + 1'b1;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_q     <= StIdle;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_p     = out_p_q;

   // Registered flags must always agree with the state they summarise.
   a_flags: assert property (@(posedge clk) disable iff (!rst_n)
      (in_ready == (state_q == StIdle)) && (busy == (state_q != StIdle)) &&
      (out_valid == (state_q == StDone)));

   a_done_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == StDone && !out_ready) |=> (out_valid && $stable(out_p)));

   a_tile_parked: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q != StBusy) |-> (mul_a == 4'h0 && mul_b == 4'h0));

   a_np_passes: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == StBusy && last_pass) |=> (state_q == StDone));

   // Keeps NP referenced as the documented pass count.
   a_np_range: assert property (@(posedge clk) (NP >= 1 && NP <= 16));

endmodule

// File: tb/tb_mult_nibble_seq.sv
// Bench for mult_nibble_seq (W=8): directed vector table, back-pressure,
// mid-operation reset, and random traffic checked through a result queue.
module tb_mult_nibble_seq;

   localparam int unsigned W = 8;
`ifdef MNS_ZERO_SKIP_EN
   localparam int ZLat = 0;
`else
   localparam int ZLat = 4;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_a, in_b;
   logic [3:0]     mul_a, mul_b;
   logic [7:0]     mul_p;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] out_p;
   logic           busy;

   mult_nibble_seq #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .busy      (busy)
   );

   // 4x4 tile model
   assign mul_p = {4'h0, mul_a} * {4'h0, mul_b};

   always #5 clk = ~clk;

   int unsigned total  = 0;
   int unsigned passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   // Scoreboard: push golden product on accept, pop on result handshake.
   logic [15:0] exp_q[$];
   int unsigned acc_cnt = 0;
   int unsigned out_cnt = 0;

   always @(negedge clk) begin
      logic [15:0] e;
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (in_valid && in_ready) begin
            e = {8'h00, in_a} * {8'h00, in_b};
            exp_q.push_back(e);
            acc_cnt++;
         end
         if (out_valid && out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL sb_unexpected: got out_p 0x%0h, required no result", out_p);
            end else begin
               check("sb_order", 32'(out_p), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      int          lat;
   } vec_t;

   vec_t       vecs[8];
   logic [7:0] seq[4];
   int         nseq;

   // Called #1 after a posedge with the DUT idle. Returns edges from the
   // accepting edge until out_valid is seen.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
      lat      = 0;
      nseq     = 0;
      while (!out_valid && lat < 20) begin
         if (nseq < 4) begin
            seq[nseq] = {mul_a, mul_b};
            nseq++;
         end
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int cyc;
      int unsigned base_out;
      int unsigned base_acc;

      vecs[0] = '{8'd3,   8'd5,   16'd15,   4};
      vecs[1] = '{8'hFF,  8'hFF,  16'hFE01, 4};
      vecs[2] = '{8'hA7,  8'h3C,  16'h2724, 4};
      vecs[3] = '{8'd0,   8'd200, 16'd0,    ZLat};
      vecs[4] = '{8'hF0,  8'h0F,  16'h0E10, 4};
      vecs[5] = '{8'h80,  8'h02,  16'h0100, 4};
      vecs[6] = '{8'hFF,  8'h01,  16'h00FF, 4};
      vecs[7] = '{8'd6,   8'd7,   16'd42,   4};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 32'({in_ready, out_valid, busy, mul_a, mul_b, out_p}),
            32'({1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000}));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      for (int k = 0; k < 8; k++) begin
         do_op(vecs[k].a, vecs[k].b, lat);
         check($sformatf("latency_%0d", k), 32'(lat), 32'(vecs[k].lat));
         check($sformatf("product_%0d", k), 32'(out_p), 32'(vecs[k].p));
         check($sformatf("tile_parked_%0d", k), 32'({mul_a, mul_b}), 32'h0);
         if (vecs[k].a == 8'hA7) begin
            check("nibble_seq_0", 32'(seq[0]), 32'h7C);
            check("nibble_seq_1", 32'(seq[1]), 32'h73);
            check("nibble_seq_2", 32'(seq[2]), 32'hAC);
            check("nibble_seq_3", 32'(seq[3]), 32'hA3);
         end
         @(posedge clk);
         #1;
         check($sformatf("idle_after_%0d", k), 32'({in_ready, out_valid, busy}), 32'b100);
         check($sformatf("out_p_kept_%0d", k), 32'(out_p), 32'(vecs[k].p));
      end

      // Back-pressure in DONE while a new request waits.
      out_ready = 1'b0;
      do_op(8'd9, 8'd9, lat);
      check("bp_latency", 32'(lat), 32'd4);
      in_valid = 1'b1;
      in_a     = 8'd12;
      in_b     = 8'd13;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp_hold_%0d", c), 32'({out_valid, in_ready, out_p}),
               32'({1'b1, 1'b0, 16'h0051}));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release", 32'({in_ready, out_valid}), 32'b10);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_next_accepted", 32'(busy), 32'd1);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("bp_next_latency", 32'(lat), 32'd4);
      check("bp_next_product", 32'(out_p), 32'd156);
      @(posedge clk);
      #1;

      // Asynchronous reset during the second pass.
      in_valid = 1'b1;
      in_a     = 8'd200;
      in_b     = 8'd100;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("abort_second_pass", 32'({mul_a, mul_b}), 32'h86);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_outputs", 32'({in_ready, out_valid, busy, mul_a, mul_b, out_p}),
            32'({1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000}));
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_op(8'd6, 8'd7, lat);
      check("post_abort_latency", 32'(lat), 32'd4);
      check("post_abort_product", 32'(out_p), 32'd42);
      @(posedge clk);
      #1;

      // Random traffic with random handshakes.
      base_out = out_cnt;
      base_acc = acc_cnt;
      cyc      = 0;
      while ((acc_cnt - base_acc) < 3000 && cyc < 60000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_a      = 8'($urandom);
         in_b      = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc       = 0;
      while (out_cnt != acc_cnt && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("rand_accepted", 32'(acc_cnt - base_acc), 32'd3000);
      check("rand_results", 32'(out_cnt - base_out), 32'd3000);
      check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
